// File: rtl/alu_exec_pipe.sv
// ---------------------------------------------------------------------------
// alu_exec_pipe
//   Two-stage pipelined ALU execute unit with valid/ready handshakes on both
//   sides. Stage 1 registers the control code and operands; stage 2 computes
//   and registers Result, Zero and Overflow. Ready propagates combinationally
//   from out_ready back to in_ready (no skid buffer), so throughput is one
//   operation per cycle when the consumer is not back-pressuring.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous; drops every in-flight operation, blocks input
//   in_valid   Control/SrcA/SrcB valid
//   in_ready   unit accepts input this cycle
//   Control    ALU code: 000 add, 001 sub, 010 and, 011 or, 101 slt
//   SrcA/SrcB  operands, WIDTH bits
//   out_valid  Result/Zero/Overflow valid
//   out_ready  consumer takes the output this cycle
//   Result     operation result, WIDTH bits
//   Zero       Result == 0
//   Overflow   signed overflow of add/sub, 0 otherwise
// ---------------------------------------------------------------------------
module alu_exec_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       Control,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b101
  } alu_op_e;

  // Stage 1 registers
  logic             s1_valid;
  logic [2:0]       s1_ctrl;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  // Stage 2 valid (data lives directly in the output registers)
  logic             s2_valid;

  logic             s1_adv;
  logic             s2_adv;

  // Stage-2 combinational results
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ov;

  // Handshake: a stage may load when it is empty or its contents move on.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv && !flush;
  assign out_valid = s2_valid;

  assign sum  = s1_a + s1_b;
  assign diff = s1_a - s1_b;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a value unassigned and no latch can be inferred.
  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    case (s1_ctrl)
      OP_ADD: begin
        alu_res = sum;
        alu_ov  = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ov  = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
      end
      OP_AND: alu_res = s1_a & s1_b;
      OP_OR:  alu_res = s1_a | s1_b;
      // Signed compare directly rather than via the sign of A-B, so the
      // answer stays correct when the subtraction overflows.
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      // Undefined codes fall through with Result = 0 (hence Zero = 1).
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ctrl <= Control;
        s1_a    <= SrcA;
        s1_b    <= SrcB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      Result   <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
    end else if (flush) begin
      // Any output handshake on this edge completes; the pipe empties.
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        Result   <= alu_res;
        Zero     <= (alu_res == '0);
        Overflow <= alu_ov;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_pipe
//   Scoreboard bench for alu_exec_pipe (WIDTH = 32). The stimulus side pushes
//   the expected response of every accepted operation into a queue; a
//   separate monitor pops and compares on every output transfer, and also
//   checks that a stalled output holds steady.
// ---------------------------------------------------------------------------
module tb_alu_exec_pipe;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    Control;
  logic [W-1:0]  SrcA;
  logic [W-1:0]  SrcB;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Result;
  logic          Zero;
  logic          Overflow;

  alu_exec_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Control   (Control),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_phase = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: operands are interpreted as mathematical signed
  // integers; overflow means the true result leaves the 32-bit signed range.
  function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, s;
    sa = a[W-1] ? longint'(a) - (64'sd1 <<< W) : longint'(a);
    sb = b[W-1] ? longint'(b) - (64'sd1 <<< W) : longint'(b);
    e.r  = '0;
    e.ov = 1'b0;
    case (c)
      3'b000: begin s = sa + sb; e.r = s[W-1:0]; e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'b001: begin s = sa - sb; e.r = s[W-1:0]; e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'b010: e.r = a & b;
      3'b011: e.r = a | b;
      3'b101: e.r = (sa < sb) ? 32'd1 : 32'd0;
      default: e.r = '0;
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  // Monitor: compares on each output transfer, checks hold during stalls.
  initial begin
    bit           held = 0;
    logic [W-1:0] h_r;
    logic         h_z, h_ov;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (held) begin
          check("stall_hold_result", Result, h_r);
          check("stall_hold_zero", Zero, h_z);
          check("stall_hold_ovf", Overflow, h_ov);
        end
        if (out_ready) begin
          held = 0;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: Result=%0h with empty scoreboard (t=%0t)", Result, $time);
          end else begin
            e = q.pop_front();
            check("result", Result, e.r);
            check("zero", Zero, e.z);
            check("overflow", Overflow, e.ov);
          end
        end else begin
          held = 1;
          h_r  = Result;
          h_z  = Zero;
          h_ov = Overflow;
        end
      end else begin
        held = 0;
      end
    end
  end

  // Random back-pressure, active only during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_phase) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Drive one operation starting at posedge+1; returns at posedge+1 after
  // the accepting edge. Bookkeeping runs just after the monitor's sample.
  task automatic issue(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 0;
    in_valid = 1'b1;
    Control  = c;
    SrcA     = a;
    SrcB     = b;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (in_ready) begin
        q.push_back(model(c, a, b));
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op %0d not accepted within 200 cycles", c);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() > 0; k++) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Control   = '0;
    SrcA      = '0;
    SrcB      = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", Result, 0);
    check("rst_zero", Zero, 0);
    check("rst_overflow", Overflow, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency of a single add: accept at edge N, valid after edge N+1
    in_valid = 1'b1; Control = 3'b000; SrcA = 32'd5; SrcB = 32'd7;
    @(negedge clk);
    check("lat_in_ready", in_ready, 1);
    check("lat_pre_valid", out_valid, 0);
    #1 q.push_back(model(3'b000, 32'd5, 32'd7));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("lat_after_n", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_after_n1", out_valid, 1);
    @(posedge clk);
    #1;

    // Directed vectors
    issue(3'b001, 32'h8000_0000, 32'h0000_0001);
    issue(3'b101, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(3'b101, 32'h7FFF_FFFF, 32'h8000_0000);
    issue(3'b001, 32'h0000_1234, 32'h0000_1234);
    issue(3'b010, 32'h0000_F0F0, 32'h0000_0FF0);
    issue(3'b011, 32'h0000_F0F0, 32'h0000_0FF0);
    issue(3'b110, 32'h0000_F0F0, 32'h0000_0FF0);
    issue(3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
    drain();

    // Back-pressure: two accepts fill the pipe, then in_ready drops
    out_ready = 1'b0;
    issue(3'b000, 32'd100, 32'd1);
    issue(3'b000, 32'd200, 32'd2);
    in_valid = 1'b1; Control = 3'b000; SrcA = 32'd300; SrcB = 32'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_first_result", Result, 101);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1 check("bp_ready_release", in_ready, 1);
    issue(3'b000, 32'd300, 32'd3);
    issue(3'b000, 32'd400, 32'd4);
    drain();

    // Flush with in_valid=1: first op completes its transfer, second dropped
    issue(3'b000, 32'd11, 32'd1);
    issue(3'b000, 32'd22, 32'd2);
    flush = 1'b1;
    in_valid = 1'b1; Control = 3'b000; SrcA = 32'd33; SrcB = 32'd3;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    #1 q.delete();
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flush_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
    end
    issue(3'b001, 32'd50, 32'd8);
    drain();

    // Async reset with two ops in flight
    out_ready = 1'b0;
    issue(3'b000, 32'd1000, 32'd1);
    issue(3'b000, 32'd2000, 32'd2);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_result", Result, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Randomized stream with random gaps and back-pressure
    rand_phase = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand());
    end
    rand_phase = 0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
